pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage SimpleRISC pipeline (IF, OF, EX, MA, RW). It combines the OF-stage data-interlock flag, EX-stage branch outcome, the multi-cycle mul/div/mod handshake and an external halt request. From these it drives every pipeline-latch enable, bubble/flush control and the PC write enable. It also keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: latch enables, bubbles, PC enable, mul/div handshake, halt drain.
// Controls are combinational in the current state; state and counters update on the rising clock edge.
module pipe_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int MC_MAX    = 64,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             is_data_interlock,
  input  logic             ex_valid,
  input  logic [4:0]       ex_opcode,
  input  logic             is_branch_taken,
  input  logic             mc_done,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             if_of_en,
  output logic             of_ex_en,
  output logic             ex_ma_en,
  output logic             ma_rw_en,
  output logic             if_of_flush,
  output logic             of_ex_bubble,
  output logic             ex_ma_bubble,
  output logic             mc_start,
  output logic             mc_timeout,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W  = $clog2(MC_MAX + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic               r_timeout;
  logic               r_halt_pend;

  logic w_mc_op;
  logic w_br;
  logic w_rules;
  logic w_pc_en, w_if_of_en, w_of_ex_en, w_ex_ma_en, w_ma_rw_en;
  logic w_if_of_flush, w_of_ex_bubble, w_ex_ma_bubble, w_mc_start, w_halted;
  logic w_stall_inc, w_flush_inc;
  logic w_wait_inc, w_wait_clr;
  logic w_drain_inc, w_drain_clr;
  logic w_pend_set, w_pend_clr;

  assign w_mc_op = ex_valid & (ex_opcode inside {5'b00010, 5'b00011, 5'b00100});
  assign w_br    = ex_valid & is_branch_taken;

  always_comb begin
    w_next_state   = r_state;
    w_rules        = 1'b0;
    w_pc_en        = 1'b0;
    w_if_of_en     = 1'b0;
    w_of_ex_en     = 1'b0;
    w_ex_ma_en     = 1'b0;
    w_ma_rw_en     = 1'b0;
    w_if_of_flush  = 1'b0;
    w_of_ex_bubble = 1'b0;
    w_ex_ma_bubble = 1'b0;
    w_mc_start     = 1'b0;
    w_halted       = 1'b0;
    w_stall_inc    = 1'b0;
    w_flush_inc    = 1'b0;
    w_wait_inc     = 1'b0;
    w_wait_clr     = 1'b0;
    w_drain_inc    = 1'b0;
    w_drain_clr    = 1'b0;
    w_pend_set     = 1'b0;
    w_pend_clr     = 1'b0;

    case (r_state)
      RUN: begin
        if (w_mc_op) begin
          w_mc_start     = 1'b1;
          w_ex_ma_bubble = 1'b1;
          w_ma_rw_en     = 1'b1;
          w_wait_clr     = 1'b1;
          w_pend_set     = halt_req;
          w_next_state   = MC_WAIT;
        end else if (halt_req || r_halt_pend) begin
          // Halt cycle: the OF instruction is discarded, so no stall or flush is counted.
          w_if_of_en     = 1'b1;
          w_of_ex_en     = 1'b1;
          w_ex_ma_en     = 1'b1;
          w_ma_rw_en     = 1'b1;
          w_if_of_flush  = 1'b1;
          w_of_ex_bubble = 1'b1;
          w_drain_clr    = 1'b1;
          w_pend_clr     = 1'b1;
          w_next_state   = DRAIN;
        end else begin
          w_rules = 1'b1;
        end
      end
      MC_WAIT: begin
        if (mc_done) begin
          w_rules    = 1'b1;
          w_wait_clr = 1'b1;
          if (r_halt_pend || halt_req) begin
            w_drain_clr  = 1'b1;
            w_pend_clr   = 1'b1;
            w_next_state = DRAIN;
          end else begin
            w_next_state = RUN;
          end
        end else begin
          w_ex_ma_bubble = 1'b1;
          w_ma_rw_en     = 1'b1;
          w_wait_inc     = 1'b1;
          w_pend_set     = halt_req;
        end
      end
      DRAIN: begin
        w_if_of_en     = 1'b1;
        w_of_ex_en     = 1'b1;
        w_ex_ma_en     = 1'b1;
        w_ma_rw_en     = 1'b1;
        w_if_of_flush  = 1'b1;
        w_of_ex_bubble = 1'b1;
        w_ex_ma_bubble = w_mc_op;
        w_drain_inc    = 1'b1;
        if (r_drain_cnt >= DRAIN_W'(DRAIN_CYC - 1)) begin
          w_next_state = HALTED;
        end
      end
      HALTED: begin
        w_halted = 1'b1;
      end
    endcase

    // Branch beats interlock: a taken branch makes the OF instruction wrong-path.
    if (w_rules) begin
      w_pc_en    = 1'b1;
      w_if_of_en = 1'b1;
      w_of_ex_en = 1'b1;
      w_ex_ma_en = 1'b1;
      w_ma_rw_en = 1'b1;
      if (w_br) begin
        w_if_of_flush  = 1'b1;
        w_of_ex_bubble = 1'b1;
        w_flush_inc    = 1'b1;
      end else if (is_data_interlock) begin
        w_pc_en        = 1'b0;
        w_if_of_en     = 1'b0;
        w_of_ex_bubble = 1'b1;
        w_stall_inc    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
      r_drain_cnt <= '0;
      r_timeout   <= 1'b0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
      if (w_wait_clr) begin
        r_wait_cnt <= '0;
      end else if (w_wait_inc && (r_wait_cnt != WAIT_W'(MC_MAX))) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_wait_inc && (r_wait_cnt >= WAIT_W'(MC_MAX - 1))) begin
        r_timeout <= 1'b1;
      end
      if (w_drain_clr) begin
        r_drain_cnt <= '0;
      end else if (w_drain_inc && (r_drain_cnt != DRAIN_W'(DRAIN_CYC))) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end
      if (w_pend_clr) begin
        r_halt_pend <= 1'b0;
      end else if (w_pend_set) begin
        r_halt_pend <= 1'b1;
      end
    end
  end

  // Combinational controls are forced low while reset is held.
  assign pc_en        = rst_n & w_pc_en;
  assign if_of_en     = rst_n & w_if_of_en;
  assign of_ex_en     = rst_n & w_of_ex_en;
  assign ex_ma_en     = rst_n & w_ex_ma_en;
  assign ma_rw_en     = rst_n & w_ma_rw_en;
  assign if_of_flush  = rst_n & w_if_of_flush;
  assign of_ex_bubble = rst_n & w_of_ex_bubble;
  assign ex_ma_bubble = rst_n & w_ex_ma_bubble;
  assign mc_start     = rst_n & w_mc_start;
  assign halted       = rst_n & w_halted;
  assign mc_timeout   = r_timeout;
  assign state        = r_state;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default instance plus a small one (MC_MAX=4, CNT_W=2) for timeout and saturation.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       is_data_interlock = 1'b0;
  logic       ex_valid = 1'b0;
  logic [4:0] ex_opcode = 5'd0;
  logic       is_branch_taken = 1'b0;
  logic       mc_done = 1'b0;
  logic       halt_req = 1'b0;

  logic        pc_en, if_of_en, of_ex_en, ex_ma_en, ma_rw_en;
  logic        if_of_flush, of_ex_bubble, ex_ma_bubble, mc_start, mc_timeout, halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  logic        b_pc_en, b_if_of_en, b_of_ex_en, b_ex_ma_en, b_ma_rw_en;
  logic        b_if_of_flush, b_of_ex_bubble, b_ex_ma_bubble, b_mc_start, b_mc_timeout, b_halted;
  logic [1:0]  b_state;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  int checks = 0;
  int errors = 0;

  // {pc, if_of, of_ex, ex_ma, ma_rw, flush, of_ex_bub, ex_ma_bub, mc_start, timeout, halted}
  wire [10:0] ctl   = {pc_en, if_of_en, of_ex_en, ex_ma_en, ma_rw_en, if_of_flush,
                       of_ex_bubble, ex_ma_bubble, mc_start, mc_timeout, halted};
  wire [10:0] b_ctl = {b_pc_en, b_if_of_en, b_of_ex_en, b_ex_ma_en, b_ma_rw_en, b_if_of_flush,
                       b_of_ex_bubble, b_ex_ma_bubble, b_mc_start, b_mc_timeout, b_halted};

  localparam logic [10:0] C_RUN   = 11'b11111000000;
  localparam logic [10:0] C_IL    = 11'b00111010000;
  localparam logic [10:0] C_BR    = 11'b11111110000;
  localparam logic [10:0] C_START = 11'b00001001100;
  localparam logic [10:0] C_WAIT  = 11'b00001001000;
  localparam logic [10:0] C_DRAIN = 11'b01111110000;
  localparam logic [10:0] C_DRMC  = 11'b01111111000;
  localparam logic [10:0] C_HALT  = 11'b00000000001;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .is_data_interlock(is_data_interlock), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .is_branch_taken(is_branch_taken), .mc_done(mc_done), .halt_req(halt_req),
    .pc_en(pc_en), .if_of_en(if_of_en), .of_ex_en(of_ex_en), .ex_ma_en(ex_ma_en), .ma_rw_en(ma_rw_en),
    .if_of_flush(if_of_flush), .of_ex_bubble(of_ex_bubble), .ex_ma_bubble(ex_ma_bubble),
    .mc_start(mc_start), .mc_timeout(mc_timeout), .halted(halted), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(2), .MC_MAX(4), .DRAIN_CYC(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .is_data_interlock(is_data_interlock), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .is_branch_taken(is_branch_taken), .mc_done(mc_done), .halt_req(halt_req),
    .pc_en(b_pc_en), .if_of_en(b_if_of_en), .of_ex_en(b_of_ex_en), .ex_ma_en(b_ex_ma_en),
    .ma_rw_en(b_ma_rw_en), .if_of_flush(b_if_of_flush), .of_ex_bubble(b_of_ex_bubble),
    .ex_ma_bubble(b_ex_ma_bubble), .mc_start(b_mc_start), .mc_timeout(b_mc_timeout),
    .halted(b_halted), .state(b_state), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  task automatic clear_inputs();
    is_data_interlock = 1'b0;
    ex_valid          = 1'b0;
    ex_opcode         = 5'd0;
    is_branch_taken   = 1'b0;
    mc_done           = 1'b0;
    halt_req          = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== 11'd0 || state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs ctl=%b state=%0d expected ctl=0 state=0", ctl, state);
    end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters stall=%0d flush=%0d expected 0 0", stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++;
      $display("FAIL reset_release_run ctl=%b expected %b", ctl, C_RUN);
    end
  endtask

  task automatic test_interlock();
    do_reset();
    is_data_interlock = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== C_IL) begin
        errors++;
        $display("FAIL interlock_cycle%0d ctl=%b expected %b", i, ctl, C_IL);
      end
      @(negedge clk);
    end
    is_data_interlock = 1'b0;
    #1;
    checks++;
    if (ctl !== C_RUN || stall_cnt !== 16'd2 || b_stall_cnt !== 2'd2) begin
      errors++;
      $display("FAIL interlock_after ctl=%b stall=%0d b_stall=%0d expected %b 2 2",
               ctl, stall_cnt, b_stall_cnt, C_RUN);
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    ex_valid = 1'b1;
    is_branch_taken = 1'b1;
    is_data_interlock = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BR) begin
      errors++;
      $display("FAIL branch_over_interlock ctl=%b expected %b", ctl, C_BR);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL branch_counters flush=%0d stall=%0d expected 1 0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_multicycle();
    do_reset();
    ex_valid = 1'b1;
    ex_opcode = 5'b00011;
    #1;
    checks++;
    if (ctl !== C_START || state !== 2'd0) begin
      errors++;
      $display("FAIL div_start ctl=%b state=%0d expected %b 0", ctl, state, C_START);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ctl !== C_WAIT || state !== 2'd1) begin
        errors++;
        $display("FAIL div_wait%0d ctl=%b state=%0d expected %b 1", i, ctl, state, C_WAIT);
      end
    end
    @(negedge clk);
    mc_done = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++;
      $display("FAIL div_done ctl=%b expected %b", ctl, C_RUN);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (ctl !== C_RUN || state !== 2'd0) begin
      errors++;
      $display("FAIL div_return ctl=%b state=%0d expected %b 0", ctl, state, C_RUN);
    end
  endtask

  task automatic test_timeout_and_async_reset();
    do_reset();
    ex_valid = 1'b1;
    ex_opcode = 5'b00010;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      // k-1 MC_WAIT cycles have completed at this sample point
      checks++;
      if (b_mc_timeout !== (k - 1 >= 4) || mc_timeout !== 1'b0 || b_state !== 2'd1) begin
        errors++;
        $display("FAIL timeout_k%0d b_timeout=%b timeout=%b b_state=%0d expected %b 0 1",
                 k, b_mc_timeout, mc_timeout, b_state, (k - 1 >= 4));
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== 11'd0 || b_ctl !== 11'd0 || state !== 2'd0 || b_state !== 2'd0) begin
      errors++;
      $display("FAIL async_reset_mid_wait ctl=%b b_ctl=%b state=%0d b_state=%0d expected all 0",
               ctl, b_ctl, state, b_state);
    end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RUN || b_ctl !== C_RUN) begin
      errors++;
      $display("FAIL async_reset_release ctl=%b b_ctl=%b expected %b", ctl, b_ctl, C_RUN);
    end
  endtask

  task automatic test_halt_during_mc();
    do_reset();
    ex_valid = 1'b1;
    ex_opcode = 5'b00010;
    @(negedge clk);
    halt_req = 1'b1;
    #1;
    checks++;
    if (state !== 2'd1 || ctl !== C_WAIT) begin
      errors++;
      $display("FAIL halt_in_wait state=%0d ctl=%b expected 1 %b", state, ctl, C_WAIT);
    end
    @(negedge clk);
    halt_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mc_done = 1'b1;
    #1;
    checks++;
    if (state !== 2'd1 || ctl !== C_RUN) begin
      errors++;
      $display("FAIL halt_done_cycle state=%0d ctl=%b expected 1 %b", state, ctl, C_RUN);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (state !== 2'd2 || ctl !== C_DRAIN) begin
      errors++;
      $display("FAIL drain1 state=%0d ctl=%b expected 2 %b", state, ctl, C_DRAIN);
    end
    @(negedge clk);
    ex_valid = 1'b1;
    ex_opcode = 5'b00100;
    is_branch_taken = 1'b1;
    #1;
    checks++;
    if (state !== 2'd2 || ctl !== C_DRMC) begin
      errors++;
      $display("FAIL drain2_kill_mc state=%0d ctl=%b expected 2 %b", state, ctl, C_DRMC);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (state !== 2'd2 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL drain3 state=%0d flush=%0d expected 2 0", state, flush_cnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (state !== 2'd3 || ctl !== C_HALT) begin
      errors++;
      $display("FAIL halted_entry state=%0d ctl=%b expected 3 %b", state, ctl, C_HALT);
    end
    ex_valid = 1'b1;
    is_branch_taken = 1'b1;
    halt_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (state !== 2'd3 || ctl !== C_HALT) begin
      errors++;
      $display("FAIL halted_sticky state=%0d ctl=%b expected 3 %b", state, ctl, C_HALT);
    end
  endtask

  task automatic test_halt_in_run();
    do_reset();
    halt_req = 1'b1;
    #1;
    checks++;
    if (ctl !== C_DRAIN || state !== 2'd0) begin
      errors++;
      $display("FAIL halt_run_cycle ctl=%b state=%0d expected %b 0", ctl, state, C_DRAIN);
    end
    @(negedge clk);
    halt_req = 1'b0;
    #1;
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL halt_run_to_drain state=%0d expected 2", state);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    is_data_interlock = 1'b1;
    repeat (5) @(negedge clk);
    is_data_interlock = 1'b0;
    ex_valid = 1'b1;
    is_branch_taken = 1'b1;
    repeat (5) @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (stall_cnt !== 16'd5 || flush_cnt !== 16'd5) begin
      errors++;
      $display("FAIL counters_wide stall=%0d flush=%0d expected 5 5", stall_cnt, flush_cnt);
    end
    checks++;
    if (b_stall_cnt !== 2'd3 || b_flush_cnt !== 2'd3) begin
      errors++;
      $display("FAIL counters_saturate b_stall=%0d b_flush=%0d expected 3 3", b_stall_cnt, b_flush_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_interlock();
    test_branch_priority();
    test_multicycle();
    test_timeout_and_async_reset();
    test_halt_during_mc();
    test_halt_in_run();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
